// File: rtl/pulse_sched_pkg.sv
// pulse_sched_pkg: shared types and round-robin search helper for the pulse scheduler
package pulse_sched_pkg;
  localparam int NUM_CH_MAX = 16;
  localparam int CH_W_MAX = $clog2(NUM_CH_MAX);
  localparam int PER_W_DEF = 8;
  localparam int PEND_W_DEF = 2;
  typedef logic [CH_W_MAX-1:0] ch_idx_t;
  typedef logic [PER_W_DEF-1:0] period_t;
  typedef logic [PEND_W_DEF-1:0] pend_t;
  typedef struct packed {
    logic found;
    ch_idx_t idx;
  } rr_res_t;
  // Walk downward so the last hit kept is the closest one after ptr.
  function automatic rr_res_t rr_next(input logic [NUM_CH_MAX-1:0] req, input ch_idx_t ptr, input int n);
    rr_res_t r;
    int j;
    r = '0;
    for (int i = n; i >= 1; i--) begin
      j = (int'(ptr) + i) % n;
      if (req[ch_idx_t'(j)]) r = '{found: 1'b1, idx: ch_idx_t'(j)};
    end
    return r;
  endfunction
endpackage

// File: rtl/pulse_rr_arbiter.sv
// pulse_rr_arbiter: combinational round-robin pick of the next requesting channel after ptr
module pulse_rr_arbiter
  import pulse_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  localparam int CW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [CW-1:0]     ptr,
  output logic [CW-1:0]     gnt_idx,
  output logic              gnt_vld
);
  rr_res_t r;
  assign r = rr_next(NUM_CH_MAX'(req), ch_idx_t'(ptr), NUM_CH);
  assign gnt_idx = CW'(r.idx);
  assign gnt_vld = r.found;
endmodule

// File: rtl/pulse_sched_ctrl.sv
// pulse_sched_ctrl: per-channel periodic pulse generators merged onto one valid/ready output
module pulse_sched_ctrl
  import pulse_sched_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int PER_W = PER_W_DEF,
  parameter int PEND_W = PEND_W_DEF,
  localparam int CW = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [CW-1:0]     cfg_ch,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic              cfg_en,
  input  logic              out_ready,
  input  logic              ovf_clr,
  output logic              out_valid,
  output logic [CW-1:0]     out_ch,
  output logic [NUM_CH-1:0] overflow,
  output logic              busy
);
  logic [PER_W-1:0] period [NUM_CH];
  logic [PER_W-1:0] cnt [NUM_CH];
  logic [PEND_W-1:0] pend [NUM_CH];
  logic [PEND_W-1:0] pend_nxt [NUM_CH];
  logic [NUM_CH-1:0] en, wr, tick, req, dec, lost;
  logic [CW-1:0] rr, gnt_idx;
  logic gnt_vld, ld;
  assign ld = !out_valid || out_ready;
  assign busy = |req || out_valid;
  // A config write reloads the counter and suppresses that channel's tick on the same edge.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    assign wr[c] = cfg_we && cfg_ch == CW'(c);
    assign tick[c] = en[c] && period[c] != '0 && cnt[c] == '0 && !wr[c];
    assign req[c] = pend[c] != '0;
    assign dec[c] = ld && gnt_vld && gnt_idx == CW'(c);
    assign lost[c] = tick[c] && !dec[c] && &pend[c];
    assign pend_nxt[c] = (tick[c] && !dec[c] && !(&pend[c])) ? pend[c] + 1'b1 :
                         (dec[c] && !tick[c]) ? pend[c] - 1'b1 : pend[c];
  end
  pulse_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .req     (req),
    .ptr     (rr),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        period[i] <= '0;
        cnt[i] <= '0;
        pend[i] <= '0;
      end
      en <= '0;
      overflow <= '0;
      out_valid <= 1'b0;
      out_ch <= '0;
      rr <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr[i]) begin
          period[i] <= cfg_period;
          en[i] <= cfg_en;
          cnt[i] <= cfg_period - 1'b1;
        end else if (en[i] && period[i] != '0) begin
          cnt[i] <= (cnt[i] == '0) ? period[i] - 1'b1 : cnt[i] - 1'b1;
        end
        pend[i] <= pend_nxt[i];
      end
      overflow <= (overflow & {NUM_CH{!ovf_clr}}) | lost;
      if (ld) begin
        out_valid <= gnt_vld;
        if (gnt_vld) begin
          out_ch <= gnt_idx;
          rr <= gnt_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_pulse_sched_ctrl.sv
// tb_pulse_sched_ctrl: directed tables/sequences plus random traffic against a timing-based model
module tb_pulse_sched_ctrl;
  localparam int N = 4;
  localparam int PMAX = 3;
  logic clk = 0;
  logic rst = 0;
  logic cfg_we = 0;
  logic [1:0] cfg_ch = 0;
  logic [7:0] cfg_period = 0;
  logic cfg_en = 0;
  logic out_ready = 0;
  logic ovf_clr = 0;
  logic out_valid;
  logic [1:0] out_ch;
  logic [3:0] overflow;
  logic busy;
  int n_chk = 0;
  int n_err = 0;
  // Model: channels tick at absolute edge numbers instead of counting down.
  longint e = 0;
  longint m_nxt [N];
  int m_per [N];
  bit m_en [N];
  int m_pend [N];
  bit [3:0] m_ovf = 0;
  bit m_v = 0;
  int m_ch = 0;
  int m_rr = 0;

  typedef struct {
    bit we; int ch; int per; bit en; bit rdy; bit ev; int ech;
  } vec_t;
  vec_t tbl [11];

  pulse_sched_ctrl dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_period(cfg_period),
    .cfg_en(cfg_en), .out_ready(out_ready), .ovf_clr(ovf_clr), .out_valid(out_valid),
    .out_ch(out_ch), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] b);
    n_chk++;
    if (a !== b) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, b, $time);
    end
  endtask

  task automatic model_edge();
    int g;
    bit tk [N];
    bit [3:0] lostv;
    int nv;
    g = -1;
    lostv = 0;
    if (!rst) begin
      for (int c = 0; c < N; c++) begin
        m_per[c] = 0; m_en[c] = 0; m_pend[c] = 0; m_nxt[c] = 0;
      end
      m_ovf = 0; m_v = 0; m_ch = 0; m_rr = 0;
    end else begin
      for (int c = 0; c < N; c++) begin
        tk[c] = m_en[c] && m_per[c] != 0 && !(cfg_we && int'(cfg_ch) == c) && e == m_nxt[c];
        if (tk[c]) m_nxt[c] += m_per[c];
      end
      if (cfg_we) begin
        m_per[cfg_ch] = int'(cfg_period);
        m_en[cfg_ch] = cfg_en;
        m_nxt[cfg_ch] = e + cfg_period;
      end
      if (!m_v || out_ready) begin
        for (int j = N; j >= 1; j--) if (m_pend[(m_rr + j) % N] > 0) g = (m_rr + j) % N;
        m_v = g >= 0;
        if (g >= 0) begin m_ch = g; m_rr = g; end
      end
      for (int c = 0; c < N; c++) begin
        nv = m_pend[c] - ((c == g) ? 1 : 0) + (tk[c] ? 1 : 0);
        if (nv > PMAX) begin nv = PMAX; lostv[c] = 1; end
        m_pend[c] = nv;
      end
      m_ovf = (ovf_clr ? 4'b0 : m_ovf) | lostv;
    end
    e++;
  endtask

  task automatic step();
    bit mb;
    model_edge();
    @(posedge clk);
    #1;
    mb = m_v;
    for (int c = 0; c < N; c++) if (m_pend[c] > 0) mb = 1;
    chk("m_valid", out_valid, m_v);
    if (m_v) chk("m_ch", out_ch, m_ch);
    chk("m_ovf", overflow, m_ovf);
    chk("m_busy", busy, mb);
  endtask

  task automatic drive(input bit we, input int ch, input int per, input bit en, input bit rdy, input bit clr);
    cfg_we = we; cfg_ch = 2'(ch); cfg_period = 8'(per); cfg_en = en; out_ready = rdy; ovf_clr = clr;
  endtask

  task automatic do_reset();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    rst = 1;
  endtask

  initial begin
    int prev, cnt_p;
    bit pat [11];
    pat = '{0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    tbl[0] = '{1, 1, 3, 1, 1, 0, 1};
    for (int i = 1; i < 11; i++) tbl[i] = '{0, 0, 0, 0, 1, pat[i], 1};
    // Reset held with a write attempted: nothing may take effect.
    rst = 0;
    drive(1, 0, 1, 1, 1, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_valid", out_valid, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
    end
    rst = 1;
    drive(0, 0, 0, 0, 1, 0);
    repeat (3) begin
      step();
      chk("post_rst_idle", out_valid, 0);
    end
    // Period 3 on channel 1 from a table.
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].we, tbl[i].ch, tbl[i].per, tbl[i].en, tbl[i].rdy, 0);
      step();
      chk("p3_valid", out_valid, tbl[i].ev);
      if (tbl[i].ev) chk("p3_ch", out_ch, tbl[i].ech);
    end
    // All channels every cycle: fair rotation.
    do_reset();
    for (int c = 0; c < N; c++) begin
      drive(1, c, 1, 1, 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 0);
    repeat (4) step();
    prev = int'(out_ch);
    for (int i = 0; i < 8; i++) begin
      step();
      chk("rr_valid", out_valid, 1);
      chk("rr_seq", out_ch, (prev + 1) % N);
      prev = int'(out_ch);
    end
    for (int c = 0; c < N; c++) begin
      drive(1, c, 0, 0, 1, 0);
      step();
    end
    drive(0, 0, 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 1, 0);
    repeat (20) step();
    chk("rr_drained_busy", busy, 0);
    chk("rr_drained_ovf", overflow, 0);
    // Back-pressure, saturation, overflow, drain.
    do_reset();
    drive(1, 2, 1, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_valid", out_valid, 1);
      chk("hold_ch", out_ch, 2);
    end
    chk("hold_pend", dut.pend[2], PMAX);
    chk("hold_ovf", overflow, 4'b0100);
    drive(1, 2, 0, 0, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 1);
    step();
    chk("ovf_clr", overflow, 0);
    drive(0, 0, 0, 0, 1, 0);
    cnt_p = 0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) cnt_p++;
      step();
    end
    chk("drain_count", cnt_p, 4);
    // Tick and grant on the same edge leave pend unchanged.
    do_reset();
    drive(1, 0, 1, 1, 1, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    step();
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("same_edge_pend", dut.pend[0], 1);
      chk("same_edge_valid", out_valid, 1);
    end
    // Rewrite mid-count restarts the period from the write.
    do_reset();
    drive(1, 3, 5, 1, 1, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    step();
    drive(1, 3, 4, 1, 1, 0);
    step();
    drive(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rewrite_wait", out_valid, 0);
    end
    step();
    chk("rewrite_fire", out_valid, 1);
    chk("rewrite_ch", out_ch, 3);
    // Reset while a pulse is stalled.
    do_reset();
    drive(1, 1, 1, 1, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0);
    repeat (4) step();
    chk("pre_rst_valid", out_valid, 1);
    rst = 0;
    step();
    rst = 1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    for (int c = 0; c < N; c++) chk("mid_rst_pend", dut.pend[c], 0);
    repeat (3) begin
      step();
      chk("mid_rst_idle", out_valid, 0);
    end
    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3), $urandom_range(0, 6),
            $urandom_range(0, 4) != 0, $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      step();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
